// File: rtl/xc_malu_long_seq_pkg.sv
// Shared definitions for the MALU long-instruction sequencer: widths, state
// and uop encodings, the captured operand bundle and the uop priority pick.
package xc_malu_long_seq_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ACC_W     = 64;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned MUL_STEPS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MSUB_1,
    ST_MACC_1,
    ST_MUL,
    ST_MMUL_ADD,
    ST_MMUL_CARRY,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    UOP_MADD,
    UOP_MSUB,
    UOP_MACC,
    UOP_MMUL
  } uop_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
  } ops_t;

  // Priority madd > msub > macc > mmul; caller qualifies with "any uop set".
  function automatic uop_t uop_pick(input logic madd, input logic msub,
                                    input logic macc);
    if (madd)      return UOP_MADD;
    else if (msub) return UOP_MSUB;
    else if (macc) return UOP_MACC;
    else           return UOP_MMUL;
  endfunction

endpackage

// File: rtl/xc_malu_long_padd.sv
// 32-bit adder/subtractor with carry/borrow-in and carry/borrow-out; the single
// adder shared by every step of the long-instruction sequencer.
module xc_malu_long_padd
  import xc_malu_long_seq_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic [XLEN-1:0] sum_c,
  output logic            cout_c
);

  localparam int unsigned EXT_W = XLEN + 1;

  logic [XLEN:0] ext;

  // In subtract mode the top bit of the 33-bit difference is the borrow.
  always_comb begin
    if (sub) ext = {1'b0, a} - {1'b0, b} - EXT_W'(cin);
    else     ext = {1'b0, a} + {1'b0, b} + EXT_W'(cin);
  end

  assign sum_c  = ext[XLEN-1:0];
  assign cout_c = ext[XLEN];

endmodule

// File: rtl/xc_malu_long_seq.sv
// Sequencer for xc.madd.3 / xc.msub.3 / xc.macc / xc.mmul.3: accepts one
// request, steps the shared adder through each instruction, returns acc.
module xc_malu_long_seq
  import xc_malu_long_seq_pkg::*;
(
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             valid,
  input  logic             flush,
  input  logic             uop_madd,
  input  logic             uop_msub,
  input  logic             uop_macc,
  input  logic             uop_mmul,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  rs3,
  output logic             ready,
  output logic [ACC_W-1:0] result,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PAD_W = ACC_W - XLEN - 1;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             carry, carry_nxt;
  logic [CNT_W-1:0] count_nxt;
  ops_t             ops, ops_nxt;

  logic [XLEN-1:0]  pa, pb, psum;
  logic             pcin, psub, pcout;
  logic             any_uop;
  uop_t             sel;

  assign any_uop = uop_madd | uop_msub | uop_macc | uop_mmul;
  assign sel     = uop_pick(uop_madd, uop_msub, uop_macc);
  assign result  = acc;

  xc_malu_long_padd u_padd (
    .a      (pa),
    .b      (pb),
    .cin    (pcin),
    .sub    (psub),
    .sum_c  (psum),
    .cout_c (pcout)
  );

  // Adder operand steering; IDLE works on live ports, later steps on latched copies.
  always_comb begin
    pa   = '0;
    pb   = '0;
    pcin = 1'b0;
    psub = 1'b0;
    case (state)
      ST_IDLE: begin
        case (sel)
          UOP_MADD: begin pa = rs1; pb = rs2; pcin = rs3[0]; end
          UOP_MSUB: begin pa = rs1; pb = rs2; psub = 1'b1; end
          UOP_MACC: begin pa = rs2; pb = rs3; end
          default:  ;
        endcase
      end
      ST_MSUB_1: begin
        pa   = acc[XLEN-1:0];
        pcin = ops.rs3[0];
        psub = 1'b1;
      end
      ST_MACC_1, ST_MMUL_CARRY: begin
        pa   = acc[ACC_W-1:XLEN];
        pcin = carry;
      end
      ST_MUL: begin
        pa = acc[ACC_W-1:XLEN];
        pb = ops.rs2[count[IDX_W-1:0]] ? ops.rs1 : '0;
      end
      ST_MMUL_ADD: begin
        pa = acc[XLEN-1:0];
        pb = ops.rs3;
      end
      default: ;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    carry_nxt = carry;
    count_nxt = count;
    ops_nxt   = ops;
    if (flush) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid && any_uop) begin
            ops_nxt = '{rs1: rs1, rs2: rs2, rs3: rs3};
            case (sel)
              UOP_MADD: begin
                acc_nxt   = {{PAD_W{1'b0}}, pcout, psum};
                state_nxt = ST_DONE;
              end
              UOP_MSUB: begin
                acc_nxt[XLEN-1:0] = psum;
                carry_nxt         = pcout;
                state_nxt         = ST_MSUB_1;
              end
              UOP_MACC: begin
                acc_nxt   = {rs1, psum};
                carry_nxt = pcout;
                state_nxt = ST_MACC_1;
              end
              default: begin
                acc_nxt   = '0;
                count_nxt = '0;
                state_nxt = ST_MUL;
              end
            endcase
          end
        end
        ST_MSUB_1: begin
          acc_nxt   = {{PAD_W{1'b0}}, carry | pcout, psum};
          state_nxt = ST_DONE;
        end
        ST_MACC_1: begin
          acc_nxt[ACC_W-1:XLEN] = psum;
          state_nxt             = ST_DONE;
        end
        ST_MUL: begin
          // Right-shifting accumulator: the low product bits drain into acc[31:0].
          acc_nxt   = {pcout, psum, acc[XLEN-1:1]};
          count_nxt = count + CNT_W'(1);
          if (count == CNT_W'(MUL_STEPS - 1)) state_nxt = ST_MMUL_ADD;
        end
        ST_MMUL_ADD: begin
          acc_nxt[XLEN-1:0] = psum;
          carry_nxt         = pcout;
          state_nxt         = ST_MMUL_CARRY;
        end
        ST_MMUL_CARRY: begin
          acc_nxt[ACC_W-1:XLEN] = psum;
          count_nxt             = '0;
          state_nxt             = ST_DONE;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
      ops   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      carry <= carry_nxt;
      count <= count_nxt;
      ops   <= ops_nxt;
      ready <= (state_nxt == ST_DONE);
      busy  <= (state_nxt != ST_IDLE);
    end
  end

endmodule
